// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame-controller state
// encoding, error codes and the bit-timing constant used by the receiver.
package uart_pkg;

  // Frame controller states
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ADDR   = 3'd1;
  localparam logic [2:0] LEN    = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] CHK    = 3'd4;
  localparam logic [2:0] COMMIT = 3'd5;

  // Error codes reported alongside frame_err
  localparam logic [1:0] ERR_BAD_LEN = 2'd0;
  localparam logic [1:0] ERR_BAD_CHK = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Receiver oversampling: clk cycles per UART bit
  localparam int CLKS_PER_BIT = 434;

  // Inter-byte timeout expressed in bit times (10 bytes of 10 bits)
  localparam int TIMEOUT_BIT_TIMES = 100;

  // Register-bank addresses wrap at 256
  function automatic logic [7:0] offset_addr(input logic [7:0] base,
                                             input logic [7:0] offset);
    return base + offset;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer for one frame: DEPTH x 8 register array, one synchronous
// write port and an asynchronous read port so the commit path can present
// a byte in the same cycle its index is known.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0]       mem [DEPTH];
  logic [DEPTH-1:0] hit;

  // One-hot decode of the write address; out-of-range addresses hit nothing
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dec
      assign hit[gi] = we && (waddr == AW'(gi));
    end
  endgenerate

  // Store the incoming byte into the addressed entry
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (hit[i]) begin
        mem[i] <= wdata;
      end
    end
  end

  // Combinational read; an out-of-range index reads as zero
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == AW'(i)) begin
        rdata = mem[i];
      end
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART receiver. Parses
// SYNC, ADDR, LEN, payload, CHK; buffers the payload, verifies the XOR
// checksum and only then replays the payload as one write per cycle.
// Rejected frames raise a one-cycle frame_err with a code and never write.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = TIMEOUT_BIT_TIMES * CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [2:0]    state;
  logic [7:0]    base_addr;
  logic [7:0]    chk_acc;
  logic [IW-1:0] len;
  logic [IW-1:0] idx;
  logic [TW-1:0] tmo_cnt;

  logic          buf_we;
  logic [IW-1:0] buf_raddr;
  logic [7:0]    buf_rdata;

  // Payload bytes land in the buffer as they arrive. Outside COMMIT the
  // read index is parked at 0 so the first commit byte is ready the moment
  // the checksum byte is accepted.
  assign buf_we    = (state == DATA) && byte_valid;
  assign buf_raddr = (state == COMMIT) ? idx : '0;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (IW)
  ) u_frame_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx),
    .wdata (byte_in),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  // Frame FSM with checksum, timeout and registered write/err outputs.
  // The first write is launched from the CHK edge; inside COMMIT, idx is
  // the index of the next write to launch, so COMMIT spans exactly the
  // cycles on which writes are visible and busy covers all of them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= '0;
      base_addr  <= '0;
      chk_acc    <= '0;
      len        <= '0;
      idx        <= '0;
      tmo_cnt    <= '0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= ERR_BAD_LEN;

      case (state)
        IDLE: begin
          if (byte_valid && (byte_in == SYNC_BYTE)) begin
            state   <= ADDR;
            busy    <= 1'b1;
            tmo_cnt <= '0;
          end
        end

        ADDR, LEN, DATA, CHK: begin
          if (byte_valid) begin
            // A byte always wins over a coincident terminal count
            tmo_cnt <= '0;
            case (state)
              ADDR: begin
                base_addr <= byte_in;
                chk_acc   <= byte_in;
                state     <= LEN;
              end
              LEN: begin
                if ((byte_in == 8'd0) || (byte_in > 8'(MAX_LEN))) begin
                  frame_err <= 1'b1;
                  err_code  <= ERR_BAD_LEN;
                  state     <= IDLE;
                  busy      <= 1'b0;
                end else begin
                  len     <= IW'(byte_in);
                  chk_acc <= chk_acc ^ byte_in;
                  idx     <= '0;
                  state   <= DATA;
                end
              end
              DATA: begin
                chk_acc <= chk_acc ^ byte_in;
                idx     <= idx + 1'b1;
                if (idx == len - 1'b1) begin
                  state <= CHK;
                end
              end
              CHK: begin
                if (byte_in == chk_acc) begin
                  state      <= COMMIT;
                  wr_en      <= 1'b1;
                  wr_addr    <= base_addr;
                  wr_data    <= buf_rdata;
                  frame_done <= (len == IW'(1));
                  idx        <= IW'(1);
                end else begin
                  frame_err <= 1'b1;
                  err_code  <= ERR_BAD_CHK;
                  state     <= IDLE;
                  busy      <= 1'b0;
                end
              end
              default: ;
            endcase
          end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 2)) begin
            // Counter reaches TIMEOUT_CYCLES-1 on this edge: abandon frame
            frame_err <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= IDLE;
            busy      <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        COMMIT: begin
          // Bytes arriving while committing are dropped and flagged
          if (byte_valid) begin
            frame_err <= 1'b1;
            err_code  <= ERR_OVERRUN;
          end
          if (idx == len) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            wr_en      <= 1'b1;
            wr_addr    <= offset_addr(base_addr, 8'(idx));
            wr_data    <= buf_rdata;
            frame_done <= (idx == len - 1'b1);
            idx        <= idx + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
